// File: rtl/dymfns_link_ctrl.sv
// dymfns_link_ctrl: stream controller for the 9-group Dy-MFNS encoder array.
// Raw 54-bit words enter through a valid/ready handshake, are registered in
// stage A to drive the encoder array, and the array's combinational codeword
// is captured in stage B. Per-group fault flags are only rewritten once both
// stages are empty, so every in-flight word is encoded with a single flag set.
module dymfns_link_ctrl #(
    parameter int NUM_GROUPS = 9,
    parameter int DATA_W     = 6,
    parameter int CODE_W     = 9,
    parameter int FLAG_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_GROUPS*DATA_W-1:0]   s_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [3:0]                     cfg_group,
    input  logic [FLAG_W-1:0]              cfg_flag,
    output logic                           cfg_err,
    output logic [NUM_GROUPS*DATA_W-1:0]   enc_data,
    output logic [NUM_GROUPS*FLAG_W-1:0]   enc_flag,
    input  logic [NUM_GROUPS*CODE_W-1:0]   code_in,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_GROUPS*CODE_W-1:0]   m_code,
    output logic                           busy
);

    localparam int RAW_W  = NUM_GROUPS * DATA_W;
    localparam int CW_W   = NUM_GROUPS * CODE_W;
    localparam int FLAGS_W = NUM_GROUPS * FLAG_W;

    // Highest legal group index plus one, sized to the cfg_group port.
    localparam logic [3:0] GROUP_LIMIT = 4'(NUM_GROUPS);

    // Flag-update controller states.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    logic [1:0]         r_state;
    logic               r_a_valid;
    logic               r_b_valid;
    logic [RAW_W-1:0]   r_enc_data;
    logic [CW_W-1:0]    r_m_code;
    logic [FLAGS_W-1:0] r_flag;
    logic               r_cfg_ready;
    logic               r_cfg_err;
    logic [3:0]         r_cfg_group;
    logic [FLAG_W-1:0]  r_cfg_flag;

    logic w_adv_b;
    logic w_s_ready;
    logic w_s_fire;
    logic w_cfg_take;
    logic w_cfg_ok;
    logic w_drained;

    // Stage A hands its word to stage B when B is empty or being emptied.
    assign w_adv_b   = r_a_valid & (~r_b_valid | m_ready);
    // Ready depends only on registered state, never on s_valid/cfg_valid.
    assign w_s_ready = (r_state == ST_RUN) & (~r_a_valid | w_adv_b);
    assign w_s_fire  = s_valid & w_s_ready;
    // While the previous request's cfg_ready pulse is out, the requester may
    // still be holding cfg_valid for that request; don't treat it as new.
    assign w_cfg_take = (r_state == ST_RUN) & cfg_valid & ~r_cfg_ready;
    assign w_cfg_ok   = (cfg_group < GROUP_LIMIT);
    assign w_drained  = ~r_a_valid & ~r_b_valid;

    // Stage A: capture accepted raw words; this register drives the array.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid  <= 1'b0;
            r_enc_data <= '0;
        end else if (w_s_fire) begin
            r_a_valid  <= 1'b1;
            r_enc_data <= s_data;
        end else if (w_adv_b) begin
            r_a_valid  <= 1'b0;
        end
    end

    // Stage B: capture the array's codeword and hold it until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_m_code  <= '0;
        end else if (w_adv_b) begin
            r_b_valid <= 1'b1;
            r_m_code  <= code_in;
        end else if (m_ready) begin
            r_b_valid <= 1'b0;
        end
    end

    // Request sequencing: RUN -> DRAIN until both stages empty -> APPLY -> RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_cfg_group <= '0;
            r_cfg_flag  <= '0;
        end else begin
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_cfg_take) begin
                        if (w_cfg_ok) begin
                            r_state     <= ST_DRAIN;
                            r_cfg_group <= cfg_group;
                            r_cfg_flag  <= cfg_flag;
                        end else begin
                            r_cfg_ready <= 1'b1;
                            r_cfg_err   <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_cfg_ready <= 1'b1;
                    r_state     <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Fault flags: rewritten only in APPLY, one group at a time.
    // NOTE: the flag bank is functional state that the array reads from the
    // first cycle, so it is reset (to all ones) rather than left as storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '1;
        end else if (r_state == ST_APPLY) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (r_cfg_group == 4'(g)) begin
                    r_flag[g*FLAG_W +: FLAG_W] <= r_cfg_flag;
                end
            end
        end
    end

    assign s_ready   = w_s_ready;
    assign enc_data  = r_enc_data;
    assign enc_flag  = r_flag;
    assign m_valid   = r_b_valid;
    assign m_code    = r_m_code;
    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign busy      = r_a_valid | r_b_valid | (r_state != ST_RUN);

endmodule
